// File: rtl/vector_uop_sequencer_if.sv
// ----------------------------------------------------------------------------
// vector_uop_sequencer_if : request / micro-op bus between decode, sequencer, lane
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vector_uop_sequencer_if #(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8
);
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int CNT_W = $clog2(VLENB) + 1;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       vsew_i;
  logic [2:0]       vlmul_i;
  logic [VL_W-1:0]  vl_i;
  logic             vill_i;
  logic [4:0]       vd_i;
  logic [4:0]       vs1_i;
  logic [4:0]       vs2_i;
  logic             uop_valid_o;
  logic             uop_ready_i;
  logic [4:0]       uop_vd_o;
  logic [4:0]       uop_vs1_o;
  logic [4:0]       uop_vs2_o;
  logic [VL_W-1:0]  uop_elem_start_o;
  logic [CNT_W-1:0] uop_elem_cnt_o;
  logic             uop_last_o;
  logic             done_o;
  logic             error_o;
  logic             flush_i;

  modport master (
    output req_valid_i, vsew_i, vlmul_i, vl_i, vill_i, vd_i, vs1_i, vs2_i,
           uop_ready_i, flush_i,
    input  req_ready_o, uop_valid_o, uop_vd_o, uop_vs1_o, uop_vs2_o,
           uop_elem_start_o, uop_elem_cnt_o, uop_last_o, done_o, error_o
  );

  modport slave (
    input  req_valid_i, vsew_i, vlmul_i, vl_i, vill_i, vd_i, vs1_i, vs2_i,
           uop_ready_i, flush_i,
    output req_ready_o, uop_valid_o, uop_vd_o, uop_vs1_o, uop_vs2_o,
           uop_elem_start_o, uop_elem_cnt_o, uop_last_o, done_o, error_o
  );
endinterface

`default_nettype wire

// File: rtl/vector_uop_sequencer.sv
// ----------------------------------------------------------------------------
// vector_uop_sequencer : splits one vector instruction into per-register uops
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vector_uop_sequencer #(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vector_uop_sequencer_if.slave  bus
);
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int CNT_W = $clog2(VLENB) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       vd_base;
  logic [4:0]       vs1_base;
  logic [4:0]       vs2_base;
  logic [2:0]       idx;
  logic [2:0]       idx_last;
  logic [CNT_W-1:0] epr;
  logic [VL_W-1:0]  start;
  logic [VL_W-1:0]  rem;
  logic             vill_q;

  logic             accept;
  logic             handshake;
  logic             last_uop;
  logic [VL_W-1:0]  epr_ext;
  logic [CNT_W-1:0] epr_req;
  logic [2:0]       idx_last_req;

  assign epr_req      = CNT_W'(VLENB >> bus.vsew_i);
  // Fractional LMUL still occupies one whole register.
  assign idx_last_req = bus.vlmul_i[2] ? 3'd0 : 3'((3'd1 << bus.vlmul_i[1:0]) - 3'd1);

  assign epr_ext   = VL_W'(epr);
  assign accept    = bus.req_valid_i && (state == IDLE) && !bus.flush_i;
  assign handshake = (state == ISSUE) && bus.uop_ready_i && !bus.flush_i;
  assign last_uop  = (rem <= epr_ext) || (idx == idx_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    bus.req_ready_o      = (state == IDLE);
    bus.uop_valid_o      = (state == ISSUE);
    bus.uop_last_o       = (state == ISSUE) && last_uop;
    bus.done_o           = (state == DONE);
    bus.error_o          = (state == DONE) && vill_q;
    bus.uop_vd_o         = vd_base  + 5'(idx);
    bus.uop_vs1_o        = vs1_base + 5'(idx);
    bus.uop_vs2_o        = vs2_base + 5'(idx);
    bus.uop_elem_start_o = start;
    bus.uop_elem_cnt_o   = (rem <= epr_ext) ? CNT_W'(rem) : epr;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.vill_i || (bus.vl_i == '0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake && last_uop) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vd_base  <= '0;
      vs1_base <= '0;
      vs2_base <= '0;
      idx      <= '0;
      idx_last <= '0;
      epr      <= '0;
      start    <= '0;
      rem      <= '0;
      vill_q   <= 1'b0;
    end else if (accept) begin
      vd_base  <= bus.vd_i;
      vs1_base <= bus.vs1_i;
      vs2_base <= bus.vs2_i;
      idx      <= '0;
      idx_last <= idx_last_req;
      epr      <= epr_req;
      start    <= '0;
      rem      <= bus.vl_i;
      vill_q   <= bus.vill_i;
    end else if (handshake) begin
      idx   <= idx + 3'd1;
      start <= start + epr_ext;
      rem   <= rem - epr_ext;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_vector_uop_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vector_uop_sequencer : randomized self-checking bench with a uop-list model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vector_uop_sequencer;
  localparam int LIMIT = 300;

  typedef struct packed {
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [6:0] start;
    logic [3:0] cnt;
    logic       last;
  } uop_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vector_uop_sequencer_if #(.VLEN(64)) bus();

  vector_uop_sequencer #(.VLEN(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  uop_t exp_q[$];
  uop_t pres_q[$];
  int   pidx_q[$];
  int   nhs;
  int   done_lat;
  bit   err, rdy_done, vld_done, rdy_after, done_after;

  // Reference: the whole uop list is derived directly from vl, EPR and group size.
  task automatic build_exp(input int sew, lmul, vl, vill, vd, vs1, vs2);
    int epr, g, n, left;
    uop_t u;
    exp_q.delete();
    epr = 8 >> sew;
    g = (lmul >= 4) ? 1 : (1 << lmul);
    n = vill ? 0 : (vl + epr - 1) / epr;
    if (n > g) n = g;
    for (int k = 0; k < n; k++) begin
      left    = vl - k * epr;
      u.vd    = 5'((vd + k) % 32);
      u.vs1   = 5'((vs1 + k) % 32);
      u.vs2   = 5'((vs2 + k) % 32);
      u.start = 7'(k * epr);
      u.cnt   = 4'((left < epr) ? left : epr);
      u.last  = (k == n - 1);
      exp_q.push_back(u);
    end
  endtask

  function automatic uop_t cur_uop();
    return {bus.uop_vd_o, bus.uop_vs1_o, bus.uop_vs2_o,
            bus.uop_elem_start_o, bus.uop_elem_cnt_o, bus.uop_last_o};
  endfunction

  // Issues one request and records every presented uop and the completion timing.
  task automatic run_instr(input int sew, lmul, vl, vill, vd, vs1, vs2,
                           input int stall_first, input int stall_pct);
    int cyc;
    bit rdy;
    pres_q.delete();
    pidx_q.delete();
    nhs = 0;
    done_lat = -1;
    err = 0; rdy_done = 0; vld_done = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.vsew_i  = 3'(sew);
    bus.vlmul_i = 3'(lmul);
    bus.vl_i    = 7'(vl);
    bus.vill_i  = 1'(vill);
    bus.vd_i    = 5'(vd);
    bus.vs1_i   = 5'(vs1);
    bus.vs2_i   = 5'(vs2);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.vsew_i  = 3'($urandom);
    bus.vlmul_i = 3'($urandom);
    bus.vl_i    = 7'($urandom);
    bus.vill_i  = 1'($urandom);
    bus.vd_i    = 5'($urandom);
    bus.vs1_i   = 5'($urandom);
    bus.vs2_i   = 5'($urandom);
    cyc = 0;
    while (cyc < LIMIT) begin
      if (bus.done_o) begin
        done_lat = cyc;
        err      = bus.error_o;
        rdy_done = bus.req_ready_o;
        vld_done = bus.uop_valid_o;
        break;
      end
      if (bus.uop_valid_o) begin
        pres_q.push_back(cur_uop());
        pidx_q.push_back(nhs);
        if (stall_first > 0) begin
          rdy = 1'b0;
          stall_first--;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        bus.uop_ready_i = rdy;
        if (rdy) nhs++;
      end else begin
        bus.uop_ready_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.uop_ready_i = 1'b0;
    @(negedge clk);
    rdy_after  = bus.req_ready_o;
    done_after = bus.done_o;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.req_ready_o, bus.uop_valid_o, bus.uop_last_o, bus.done_o, bus.error_o} !== 5'b10000
        || cur_uop() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ctl=%b uop=%h, want ctl=10000 uop=0",
               {bus.req_ready_o, bus.uop_valid_o, bus.uop_last_o, bus.done_o, bus.error_o}, cur_uop());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    uop_t want;
    build_exp(2, 2, 7, 0, 8, 24, 16);
    run_instr(2, 2, 7, 0, 8, 24, 16, 0, 0);
    vectors++;
    if (nhs !== 4 || exp_q.size() !== 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d uops, want 4 (model %0d)", nhs, exp_q.size());
    end
    foreach (pres_q[j]) begin
      want = (pidx_q[j] < exp_q.size()) ? exp_q[pidx_q[j]] : '0;
      vectors++;
      if (pidx_q[j] >= exp_q.size() || pres_q[j] !== want) begin
        miscompares++;
        $display("FAIL basic_uop%0d: got %h want %h", j, pres_q[j], want);
      end
    end
    vectors++;
    if (done_lat !== 4 || {err, rdy_done, vld_done, rdy_after, done_after} !== 5'b00010) begin
      miscompares++;
      $display("FAIL basic_done: lat=%0d flags=%b, want lat=4 flags=00010",
               done_lat, {err, rdy_done, vld_done, rdy_after, done_after});
    end
  endtask

  task automatic test_no_uop();
    for (int v = 0; v < 2; v++) begin
      run_instr(1, 0, (v == 0) ? 0 : 3, v, 1, 2, 3, 0, 0);
      vectors++;
      if (pres_q.size() !== 0 || done_lat !== 0
          || {err, rdy_done, vld_done, rdy_after, done_after} !== {1'(v), 4'b0010}) begin
        miscompares++;
        $display("FAIL no_uop_%0d: uops=%0d lat=%0d flags=%b, want uops=0 lat=0 flags=%b",
                 v, pres_q.size(), done_lat, {err, rdy_done, vld_done, rdy_after, done_after},
                 {1'(v), 4'b0010});
      end
    end
  endtask

  task automatic test_backpressure();
    uop_t want;
    build_exp(0, 0, 8, 0, 5, 6, 7);
    run_instr(0, 0, 8, 0, 5, 6, 7, 3, 0);
    want = (exp_q.size() > 0) ? exp_q[0] : '0;
    vectors++;
    if (pres_q.size() !== 4 || nhs !== 1 || want.cnt !== 4'd8 || want.last !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_count: presented %0d cycles %0d handshakes, want 4 and 1",
               pres_q.size(), nhs);
    end
    foreach (pres_q[j]) begin
      vectors++;
      if (pres_q[j] !== want) begin
        miscompares++;
        $display("FAIL hold_stable%0d: got %h want %h", j, pres_q[j], want);
      end
    end
    vectors++;
    if (done_lat !== 4 || {err, rdy_done, vld_done, rdy_after} !== 4'b0001) begin
      miscompares++;
      $display("FAIL hold_done: lat=%0d flags=%b, want lat=4 flags=0001",
               done_lat, {err, rdy_done, vld_done, rdy_after});
    end
  endtask

  task automatic test_fractional();
    uop_t want;
    int cfg [2][3] = '{'{0, 7, 4}, '{3, 2, 4}};
    for (int c = 0; c < 2; c++) begin
      build_exp(cfg[c][0], cfg[c][1], cfg[c][2], 0, (c == 0) ? 3 : 30, 31, 29);
      run_instr(cfg[c][0], cfg[c][1], cfg[c][2], 0, (c == 0) ? 3 : 30, 31, 29, 0, 20);
      vectors++;
      if (nhs !== ((c == 0) ? 1 : 4) || nhs !== exp_q.size()) begin
        miscompares++;
        $display("FAIL frac%0d_count: got %0d uops, want %0d", c, nhs, (c == 0) ? 1 : 4);
      end
      foreach (pres_q[j]) begin
        want = (pidx_q[j] < exp_q.size()) ? exp_q[pidx_q[j]] : '0;
        vectors++;
        if (pidx_q[j] >= exp_q.size() || pres_q[j] !== want) begin
          miscompares++;
          $display("FAIL frac%0d_uop%0d: got %h want %h", c, j, pres_q[j], want);
        end
      end
      vectors++;
      if (done_lat !== pres_q.size() || {err, rdy_after} !== 2'b01) begin
        miscompares++;
        $display("FAIL frac%0d_done: lat=%0d err=%b rdy=%b, want lat=%0d err=0 rdy=1",
                 c, done_lat, err, rdy_after, pres_q.size());
      end
    end
  endtask

  task automatic test_flush();
    int cyc;
    int hs;
    uop_t want;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.vsew_i = 3'd2; bus.vlmul_i = 3'd2; bus.vl_i = 7'd8; bus.vill_i = 1'b0;
    bus.vd_i = 5'd4; bus.vs1_i = 5'd5; bus.vs2_i = 5'd6;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    hs = 0;
    cyc = 0;
    while (hs < 2 && cyc < 50) begin
      if (bus.uop_valid_o) begin
        bus.uop_ready_i = 1'b1;
        if (hs == 1) bus.flush_i = 1'b1;
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.flush_i = 1'b0;
    bus.uop_ready_i = 1'b0;
    vectors++;
    if (hs !== 2 || {bus.uop_valid_o, bus.done_o, bus.error_o, bus.req_ready_o} !== 4'b0001) begin
      miscompares++;
      $display("FAIL flush_idle: hs=%0d valid/done/err/ready=%b, want hs=2 0001",
               hs, {bus.uop_valid_o, bus.done_o, bus.error_o, bus.req_ready_o});
    end
    @(negedge clk);
    vectors++;
    if (bus.done_o !== 1'b0 || bus.uop_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done: done=%b valid=%b, want 0 0", bus.done_o, bus.uop_valid_o);
    end
    build_exp(1, 1, 5, 0, 20, 21, 22);
    run_instr(1, 1, 5, 0, 20, 21, 22, 0, 0);
    foreach (pres_q[j]) begin
      want = (pidx_q[j] < exp_q.size()) ? exp_q[pidx_q[j]] : '0;
      vectors++;
      if (pidx_q[j] >= exp_q.size() || pres_q[j] !== want) begin
        miscompares++;
        $display("FAIL flush_next_uop%0d: got %h want %h", j, pres_q[j], want);
      end
    end
    vectors++;
    if (nhs !== 2 || done_lat !== 2 || rdy_after !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_next_done: uops=%0d lat=%0d rdy=%b, want 2 2 1", nhs, done_lat, rdy_after);
    end
  endtask

  task automatic test_reset_mid();
    uop_t want;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.vsew_i = 3'd0; bus.vlmul_i = 3'd3; bus.vl_i = 7'd40; bus.vill_i = 1'b0;
    bus.vd_i = 5'd9; bus.vs1_i = 5'd10; bus.vs2_i = 5'd11;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.uop_ready_i = 1'b1;
    @(negedge clk);
    bus.uop_ready_i = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.req_ready_o, bus.uop_valid_o, bus.uop_last_o, bus.done_o, bus.error_o} !== 5'b10000
        || cur_uop() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ctl=%b uop=%h, want ctl=10000 uop=0",
               {bus.req_ready_o, bus.uop_valid_o, bus.uop_last_o, bus.done_o, bus.error_o}, cur_uop());
    end
    @(negedge clk);
    reset_n = 1'b1;
    build_exp(0, 1, 12, 0, 31, 0, 1);
    run_instr(0, 1, 12, 0, 31, 0, 1, 0, 30);
    foreach (pres_q[j]) begin
      want = (pidx_q[j] < exp_q.size()) ? exp_q[pidx_q[j]] : '0;
      vectors++;
      if (pidx_q[j] >= exp_q.size() || pres_q[j] !== want) begin
        miscompares++;
        $display("FAIL reset_next_uop%0d: got %h want %h", j, pres_q[j], want);
      end
    end
    vectors++;
    if (nhs !== 2 || done_lat !== pres_q.size() || rdy_after !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_next_done: uops=%0d lat=%0d rdy=%b, want 2 %0d 1",
               nhs, done_lat, rdy_after, pres_q.size());
    end
  endtask

  task automatic test_random();
    int lm_tab [7] = '{0, 1, 2, 3, 5, 6, 7};
    int sew, lmul, epr, vlmax, vl, vill;
    uop_t want;
    for (int t = 0; t < 40; t++) begin
      sew  = $urandom_range(3);
      lmul = lm_tab[$urandom_range(6)];
      epr  = 8 >> sew;
      vlmax = (lmul >= 4) ? (epr >> (8 - lmul)) : (epr << lmul);
      vl   = ($urandom_range(9) == 0) ? $urandom_range(127) : $urandom_range(vlmax);
      vill = ($urandom_range(9) == 0);
      build_exp(sew, lmul, vl, vill, $urandom_range(31), $urandom_range(31), $urandom_range(31));
      if (exp_q.size() > 0) begin
        want = exp_q[0];
        run_instr(sew, lmul, vl, vill, want.vd, want.vs1, want.vs2, 0, $urandom_range(60));
      end else begin
        run_instr(sew, lmul, vl, vill, 0, 0, 0, 0, 0);
      end
      vectors++;
      if (nhs !== exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_count: got %0d uops, want %0d", t, nhs, exp_q.size());
      end
      foreach (pres_q[j]) begin
        want = (pidx_q[j] < exp_q.size()) ? exp_q[pidx_q[j]] : '0;
        vectors++;
        if (pidx_q[j] >= exp_q.size() || pres_q[j] !== want) begin
          miscompares++;
          $display("FAIL rand%0d_uop%0d: got %h want %h", t, j, pres_q[j], want);
        end
      end
      vectors++;
      if (done_lat !== pres_q.size()
          || {err, rdy_done, vld_done, rdy_after, done_after} !== {1'(vill), 4'b0010}) begin
        miscompares++;
        $display("FAIL rand%0d_done: lat=%0d flags=%b, want lat=%0d flags=%b", t, done_lat,
                 {err, rdy_done, vld_done, rdy_after, done_after}, pres_q.size(), {1'(vill), 4'b0010});
      end
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.vsew_i = '0; bus.vlmul_i = '0; bus.vl_i = '0; bus.vill_i = 1'b0;
    bus.vd_i = '0; bus.vs1_i = '0; bus.vs2_i = '0;
    bus.uop_ready_i = 1'b0;
    bus.flush_i = 1'b0;
    test_reset();
    test_basic();
    test_no_uop();
    test_backpressure();
    test_fractional();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
